// File: rtl/io_bus_if.sv
// CPU MEM-stage bus port: address, write strobe and data toward the bridge,
// combinational read data back to the CPU.
interface io_bus_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/io_bridge.sv
// Memory-mapped bridge between the CPU bus port and DRAM / on-board peripherals
// (LEDs, switches, buttons, 8-digit seven-segment scan driver, free-running timer).
module io_bridge #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [31:0] TIMER_INC = 32'd1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  io_bus_if.slave     bus,
  output logic [13:0] dram_addr,
  output logic        dram_we,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw_i,
  input  logic [4:0]  button_i,
  output logic [23:0] led_o,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam logic [31:0] ADDR_PERIPH = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN    = 32'hFFFF_F078;

  localparam int unsigned    CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  logic is_dram, is_dig, is_timer, is_led, is_sw, is_btn;
  logic wr_dig, wr_timer, wr_led;

  logic [31:0]      dig_q, dig_d;
  logic [31:0]      timer_q, timer_d;
  logic [23:0]      led_q, led_d;
  logic [23:0]      sw_s1_q, sw_s2_q;
  logic [4:0]       btn_s1_q, btn_s2_q;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dig_en_q, dig_en_d;
  logic [7:0]       dig_seg_q, dig_seg_d;

  // Full 32-bit compare: aliases inside the peripheral page stay unmapped.
  always_comb begin
    is_dram  = (bus.Bus_addr < ADDR_PERIPH);
    is_dig   = (bus.Bus_addr == ADDR_DIG);
    is_timer = (bus.Bus_addr == ADDR_TIMER);
    is_led   = (bus.Bus_addr == ADDR_LED);
    is_sw    = (bus.Bus_addr == ADDR_SW);
    is_btn   = (bus.Bus_addr == ADDR_BTN);
    wr_dig   = bus.Bus_wen & is_dig;
    wr_timer = bus.Bus_wen & is_timer;
    wr_led   = bus.Bus_wen & is_led;
  end

  assign dram_addr  = bus.Bus_addr[15:2];
  assign dram_we    = bus.Bus_wen & is_dram;
  assign dram_wdata = bus.Bus_wdata;

  // Combinational read path: the CPU latches this into MEM/WB in the same cycle.
  always_comb begin
    bus.Bus_rdata = 32'h0;
    if (is_dram)       bus.Bus_rdata = dram_rdata;
    else if (is_dig)   bus.Bus_rdata = dig_q;
    else if (is_timer) bus.Bus_rdata = timer_q;
    else if (is_led)   bus.Bus_rdata = {8'h00, led_q};
    else if (is_sw)    bus.Bus_rdata = {8'h00, sw_s2_q};
    else if (is_btn)   bus.Bus_rdata = {27'h0, btn_s2_q};
  end

  always_comb begin
    dig_d   = wr_dig ? bus.Bus_wdata : dig_q;
    led_d   = wr_led ? bus.Bus_wdata[23:0] : led_q;
    timer_d = wr_timer ? bus.Bus_wdata : (timer_q + TIMER_INC);
  end

  // Scan driver: outputs are registered from the current idx, so they lag by one cycle.
  always_comb begin
    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + CNT_W'(1);
      idx_d      = idx_q;
    end
    dig_en_d  = ~(8'h01 << idx_q);
    dig_seg_d = hex_to_seg(dig_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_q      <= '0;
      timer_q    <= '0;
      led_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      dig_en_q   <= 8'hFE;
      dig_seg_q  <= 8'hC0;
    end else begin
      dig_q      <= dig_d;
      timer_q    <= timer_d;
      led_q      <= led_d;
      sw_s1_q    <= sw_i;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= button_i;
      btn_s2_q   <= btn_s1_q;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      dig_en_q   <= dig_en_d;
      dig_seg_q  <= dig_seg_d;
    end
  end

  assign led_o   = led_q;
  assign dig_en  = dig_en_q;
  assign dig_seg = dig_seg_q;

endmodule

// File: tb/tb_io_bridge.sv
// Randomized self-checking bench for io_bridge against a cycle-count based
// behavioural model of the memory map, timer, input sync and display scan.
module tb_io_bridge;
  localparam int unsigned SD   = 2;
  localparam logic [31:0] TINC = 32'd1;
  localparam logic [7:0]  SEG_LUT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw_i;
  logic [4:0]  button_i;
  logic [23:0] led_o;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  io_bus_if bus ();

  io_bridge #(.SCAN_DIV(SD), .TIMER_INC(TINC)) dut (
    .cpu_clk    (clk),
    .cpu_rst    (rst),
    .bus        (bus),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw_i       (sw_i),
    .button_i   (button_i),
    .led_o      (led_o),
    .dig_en     (dig_en),
    .dig_seg    (dig_seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_dig, m_timer;
  logic [23:0] m_led, m_sw1, m_sw2;
  logic [4:0]  m_btn1, m_btn2;
  logic [7:0]  m_en, m_seg;
  int unsigned m_cyc;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'hFFFF_F000) return dram_rdata;
    case (a)
      32'hFFFF_F000: return m_dig;
      32'hFFFF_F020: return m_timer;
      32'hFFFF_F060: return {8'h00, m_led};
      32'hFFFF_F070: return {8'h00, m_sw2};
      32'hFFFF_F078: return {27'h0, m_btn2};
      default:       return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.Bus_addr  = a;
    bus.Bus_wen   = w;
    bus.Bus_wdata = d;
    #1;
  endtask

  // Advance the model by one clock edge from the current inputs, then clock the DUT.
  task automatic tick();
    int unsigned idx;
    logic [31:0] a;
    a = bus.Bus_addr;
    if (rst) begin
      m_dig = 0; m_timer = 0; m_led = 0; m_sw1 = 0; m_sw2 = 0;
      m_btn1 = 0; m_btn2 = 0; m_en = 8'hFE; m_seg = 8'hC0; m_cyc = 0;
    end else begin
      idx   = (m_cyc / SD) % 8;
      m_en  = ~(8'h01 << idx);
      m_seg = SEG_LUT[m_dig[idx*4 +: 4]];
      m_cyc = m_cyc + 1;
      m_sw2 = m_sw1;   m_sw1 = sw_i;
      m_btn2 = m_btn1; m_btn1 = button_i;
      if (bus.Bus_wen && a == 32'hFFFF_F000) m_dig = bus.Bus_wdata;
      if (bus.Bus_wen && a == 32'hFFFF_F060) m_led = bus.Bus_wdata[23:0];
      m_timer = (bus.Bus_wen && a == 32'hFFFF_F020) ? bus.Bus_wdata : m_timer + TINC;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(32'h0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw_i = 24'h5A5A5A; button_i = 5'h1F;
    drive(32'hFFFF_F020, 1'b1, 32'h1234_0000);
    tick(); tick();
    n_checks++; if (led_o !== 24'h0) begin n_errors++; $display("FAIL reset_led got %h want %h", led_o, 24'h0); end
    n_checks++; if (dig_en !== 8'hFE) begin n_errors++; $display("FAIL reset_dig_en got %h want %h", dig_en, 8'hFE); end
    n_checks++; if (dig_seg !== 8'hC0) begin n_errors++; $display("FAIL reset_dig_seg got %h want %h", dig_seg, 8'hC0); end
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_timer got %h want %h", bus.Bus_rdata, 32'h0); end
    rst = 1'b0;
    drive(32'hFFFF_F070, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_sw_read got %h want %h", bus.Bus_rdata, 32'h0); end
    sw_i = 24'h0; button_i = 5'h0;
  endtask

  task automatic test_dram();
    logic [31:0] a, d;
    logic w;
    dram_rdata = 32'h0;
    drive(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
    n_checks++; if (dram_addr !== 14'd4) begin n_errors++; $display("FAIL dram_addr got %h want %h", dram_addr, 14'd4); end
    n_checks++; if (dram_we !== 1'b1) begin n_errors++; $display("FAIL dram_we got %b want 1", dram_we); end
    n_checks++; if (dram_wdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL dram_wdata got %h want deadbeef", dram_wdata); end
    tick();
    dram_rdata = 32'h1234_5678;
    drive(32'h0000_0010, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL dram_read got %h want 12345678", bus.Bus_rdata); end
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(32'hFFFF_EFFF, 0);
      if (i == 0) a = 32'hFFFF_EFFC;
      w = 1'($urandom);
      d = $urandom;
      dram_rdata = $urandom;
      drive(a, w, d);
      n_checks++;
      if (dram_addr !== a[15:2] || dram_we !== w || dram_wdata !== d || bus.Bus_rdata !== dram_rdata) begin
        n_errors++;
        $display("FAIL dram_rand addr %h got a=%h we=%b wd=%h rd=%h want a=%h we=%b wd=%h rd=%h",
                 a, dram_addr, dram_we, dram_wdata, bus.Bus_rdata, a[15:2], w, d, dram_rdata);
      end
      tick();
    end
  endtask

  task automatic test_led();
    drive(32'hFFFF_F060, 1'b1, 32'hFFA5_5A0F);
    n_checks++; if (dram_we !== 1'b0) begin n_errors++; $display("FAIL led_dram_we got %b want 0", dram_we); end
    tick();
    n_checks++; if (led_o !== 24'hA55A0F) begin n_errors++; $display("FAIL led_write got %h want a55a0f", led_o); end
    drive(32'hFFFF_F060, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'h00A5_5A0F) begin n_errors++; $display("FAIL led_read got %h want 00a55a0f", bus.Bus_rdata); end
    drive(32'hFFFF_F070, 1'b1, 32'h0000_0000);
    n_checks++; if (dram_we !== 1'b0) begin n_errors++; $display("FAIL sw_write_dram_we got %b want 0", dram_we); end
    tick();
    n_checks++; if (led_o !== 24'hA55A0F) begin n_errors++; $display("FAIL led_after_sw_write got %h want a55a0f", led_o); end
    drive(32'hFFFF_F064, 1'b1, 32'h0000_0001);
    tick();
    n_checks++; if (led_o !== m_led || m_led !== 24'hA55A0F) begin n_errors++; $display("FAIL led_alias_write got %h want a55a0f", led_o); end
  endtask

  task automatic test_sw_sync();
    sw_i = 24'h0; button_i = 5'h0;
    drive(32'hFFFF_F070, 1'b0, 32'h0);
    tick(); tick();
    sw_i = 24'h000081;
    tick();
    n_checks++; if (bus.Bus_rdata !== 32'h0) begin n_errors++; $display("FAIL sw_edge1 got %h want 0", bus.Bus_rdata); end
    tick();
    n_checks++; if (bus.Bus_rdata !== 32'h0000_0081) begin n_errors++; $display("FAIL sw_edge2 got %h want 81", bus.Bus_rdata); end
    button_i = 5'h13;
    drive(32'hFFFF_F078, 1'b0, 32'h0);
    tick(); tick();
    n_checks++; if (bus.Bus_rdata !== 32'h0000_0013) begin n_errors++; $display("FAIL btn_read got %h want 13", bus.Bus_rdata); end
    drive(32'hFFFF_F100, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'h0) begin n_errors++; $display("FAIL unmapped_read got %h want 0", bus.Bus_rdata); end
  endtask

  task automatic test_timer();
    do_reset();
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (bus.Bus_rdata !== 32'd5) begin n_errors++; $display("FAIL timer_cycle5 got %h want 5", bus.Bus_rdata); end
    drive(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFE);
    tick();
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL timer_load got %h want fffffffe", bus.Bus_rdata); end
    tick();
    n_checks++; if (bus.Bus_rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL timer_inc got %h want ffffffff", bus.Bus_rdata); end
    tick();
    n_checks++; if (bus.Bus_rdata !== 32'h0) begin n_errors++; $display("FAIL timer_wrap got %h want 0", bus.Bus_rdata); end
  endtask

  task automatic test_scan();
    do_reset();
    drive(32'hFFFF_F000, 1'b1, 32'h7654_3210);
    tick();
    drive(32'hFFFF_F000, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'h7654_3210) begin n_errors++; $display("FAIL dig_read got %h want 76543210", bus.Bus_rdata); end
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (dig_en !== m_en || dig_seg !== m_seg) begin
        n_errors++;
        $display("FAIL scan cyc %0d got en=%h seg=%h want en=%h seg=%h", m_cyc, dig_en, dig_seg, m_en, m_seg);
      end
      if (m_cyc == 7) begin
        n_checks++; if (dig_en !== 8'hF7 || dig_seg !== 8'hB0) begin n_errors++; $display("FAIL scan_digit3 got en=%h seg=%h want en=f7 seg=b0", dig_en, dig_seg); end
      end
      if (m_cyc == 17) begin
        n_checks++; if (dig_en !== 8'hFE || dig_seg !== 8'hC0) begin n_errors++; $display("FAIL scan_wrap got en=%h seg=%h want en=fe seg=c0", dig_en, dig_seg); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int guard;
    do_reset();
    drive(32'hFFFF_F060, 1'b1, 32'h00FF_FFFF); tick();
    drive(32'hFFFF_F020, 1'b1, 32'd1000);      tick();
    drive(32'hFFFF_F000, 1'b1, 32'hABCD_EF12); tick();
    drive(32'h0000_0100, 1'b0, 32'h0);
    guard = 0;
    while (((m_cyc / SD) % 8) != 5 && guard < 40) begin tick(); guard++; end
    n_checks++; if (guard >= 40) begin n_errors++; $display("FAIL midrun_reach_idx5 got guard=%0d want <40", guard); end
    rst = 1'b1;
    drive(32'h0000_0040, 1'b1, 32'h1111_1111);
    n_checks++; if (dram_we !== 1'b1) begin n_errors++; $display("FAIL midrun_dram_we got %b want 1", dram_we); end
    drive(32'hFFFF_F060, 1'b1, 32'h0012_3456);
    tick();
    n_checks++; if (led_o !== 24'h0) begin n_errors++; $display("FAIL midrun_led got %h want 0", led_o); end
    n_checks++; if (dig_en !== 8'hFE || dig_seg !== 8'hC0) begin n_errors++; $display("FAIL midrun_scan got en=%h seg=%h want en=fe seg=c0", dig_en, dig_seg); end
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    n_checks++; if (bus.Bus_rdata !== 32'h0) begin n_errors++; $display("FAIL midrun_timer got %h want 0", bus.Bus_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, exp;
    logic w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(9, 0))
        0, 1:    a = $urandom_range(32'hFFFF_EFFF, 0);
        2:       a = 32'hFFFF_F000;
        3:       a = 32'hFFFF_F020;
        4:       a = 32'hFFFF_F060;
        5:       a = 32'hFFFF_F070;
        6:       a = 32'hFFFF_F078;
        7:       a = 32'hFFFF_F000 | {20'h0, 10'($urandom), 2'b00};
        default: a = 32'hFFFF_F000 | {20'h0, 12'($urandom)};
      endcase
      w = 1'($urandom);
      rst = ($urandom_range(59, 0) == 0);
      dram_rdata = $urandom;
      if ($urandom_range(3, 0) == 0) sw_i = 24'($urandom);
      if ($urandom_range(3, 0) == 0) button_i = 5'($urandom);
      drive(a, w, $urandom);
      exp = m_read(a);
      n_checks++;
      if (bus.Bus_rdata !== exp || dram_we !== (w && a < 32'hFFFF_F000)) begin
        n_errors++;
        $display("FAIL rand_read addr %h got rd=%h we=%b want rd=%h we=%b", a, bus.Bus_rdata, dram_we, exp, (w && a < 32'hFFFF_F000));
      end
      tick();
      n_checks++;
      if (led_o !== m_led || dig_en !== m_en || dig_seg !== m_seg) begin
        n_errors++;
        $display("FAIL rand_state got led=%h en=%h seg=%h want led=%h en=%h seg=%h", led_o, dig_en, dig_seg, m_led, m_en, m_seg);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw_i = 24'h0; button_i = 5'h0; dram_rdata = 32'h0;
    bus.Bus_addr = 32'h0; bus.Bus_wen = 1'b0; bus.Bus_wdata = 32'h0;
    test_reset();
    test_dram();
    test_led();
    test_sw_sync();
    test_timer();
    test_scan();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
